mem_bus_arbiter: RTL and testbench

- Shares the single core memory bus between the IFU (read-only) and the LSU (read or write).
- Sits between the fetch/MEM stages and the memory interface.
- Drives lsu_idle, which the MEM/WB pipeline register uses as its mem_idle/ready input.
- Fixed LSU priority with a starvation guard for the IFU; one outstanding transaction at a time.

---
 rtl/mem_bus_arbiter_pkg.sv | 13 +
 rtl/mem_arb_streak_cnt.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encoding and default widths for the memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 64;
    localparam int MAX_LSU_STREAK_DEF = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

endpackage

// File: rtl/mem_arb_streak_cnt.sv
// rtl/mem_arb_streak_cnt.sv - saturating count of LSU grants made while the IFU is kept waiting
module mem_arb_streak_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == CW'(MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the core memory bus between IFU reads and LSU reads/writes
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_LSU_STREAK = MAX_LSU_STREAK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_r_ready,
    input  logic [ADDR_W-1:0]   ifu_r_addr,
    output logic                ifu_gnt,
    output logic                ifu_r_valid,
    output logic [DATA_W-1:0]   ifu_r_data,
    input  logic                lsu_r_ready,
    input  logic                lsu_w_valid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_w_data,
    input  logic [DATA_W/8-1:0] lsu_w_strb,
    output logic                lsu_gnt,
    output logic                lsu_r_valid,
    output logic [DATA_W-1:0]   lsu_r_data,
    output logic                lsu_w_ready,
    output logic                lsu_idle,
    output logic                mem_r_ready,
    output logic [ADDR_W-1:0]   mem_r_addr,
    input  logic                mem_r_valid,
    input  logic [DATA_W-1:0]   mem_r_data,
    output logic                mem_w_valid,
    output logic [ADDR_W-1:0]   mem_w_addr,
    output logic [DATA_W-1:0]   mem_w_data,
    output logic [DATA_W/8-1:0] mem_w_strb,
    input  logic                mem_w_ready
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              can_grant;
    logic              lsu_req;
    logic              streak_sat;
    logic              ifu_grant;
    logic              lsu_grant;

    // Grants are suppressed while reset is held so every output sits at its reset value.
    assign can_grant = (state == IDLE) && !rst;
    assign lsu_req   = lsu_w_valid || lsu_r_ready;
    assign lsu_grant = can_grant && lsu_req && !(ifu_r_ready && streak_sat);
    assign ifu_grant = can_grant && ifu_r_ready && !lsu_grant;
    assign ifu_gnt   = ifu_grant;
    assign lsu_gnt   = lsu_grant;

    mem_arb_streak_cnt #(
        .MAX (MAX_LSU_STREAK)
    ) u_streak (
        .clk (clk),
        .rst (rst),
        .inc (lsu_grant && ifu_r_ready),
        .clr (ifu_grant || (lsu_grant && !ifu_r_ready)),
        .sat (streak_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (ifu_grant || lsu_grant) begin
            addr_q  <= lsu_grant ? lsu_addr : ifu_r_addr;
            wdata_q <= lsu_w_data;
            wstrb_q <= lsu_w_strb;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu_grant) begin
                    state_nxt = lsu_w_valid ? LSU_WR : LSU_RD;
                end else if (ifu_grant) begin
                    state_nxt = IFU_RD;
                end
            end
            IFU_RD, LSU_RD: if (mem_r_valid) state_nxt = IDLE;
            LSU_WR:         if (mem_w_ready) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Responses of the wrong kind for the current state never reach a requester.
    assign ifu_r_valid = (state == IFU_RD) && mem_r_valid;
    assign ifu_r_data  = ifu_r_valid ? mem_r_data : '0;
    assign lsu_r_valid = (state == LSU_RD) && mem_r_valid;
    assign lsu_r_data  = lsu_r_valid ? mem_r_data : '0;
    assign lsu_w_ready = (state == LSU_WR) && mem_w_ready;
    assign lsu_idle    = !(lsu_grant || state == LSU_RD || state == LSU_WR);

    assign mem_r_ready = (state == IFU_RD) || (state == LSU_RD);
    assign mem_r_addr  = mem_r_ready ? addr_q : '0;
    assign mem_w_valid = (state == LSU_WR);
    assign mem_w_addr  = mem_w_valid ? addr_q : '0;
    assign mem_w_data  = mem_w_valid ? wdata_q : '0;
    assign mem_w_strb  = mem_w_valid ? wstrb_q : '0;

    a_lsu_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(lsu_w_valid && lsu_r_ready))
        else $warning("lsu_w_valid and lsu_r_ready both high, write takes priority");

    a_ifu_req_held: assert property (@(posedge clk) disable iff (rst)
        (ifu_r_ready && !ifu_gnt) |=> ifu_r_ready)
        else $error("IFU request dropped before ifu_gnt");

    a_lsu_req_held: assert property (@(posedge clk) disable iff (rst)
        (lsu_req && !lsu_gnt) |=> (lsu_w_valid || lsu_r_ready))
        else $error("LSU request dropped before lsu_gnt");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with directed and random traffic
module tb_mem_bus_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_r_ready, ifu_gnt, ifu_r_valid;
    logic [AW-1:0] ifu_r_addr;
    logic [DW-1:0] ifu_r_data;
    logic          lsu_r_ready, lsu_w_valid, lsu_gnt, lsu_r_valid, lsu_w_ready, lsu_idle;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_w_data, lsu_r_data;
    logic [SW-1:0] lsu_w_strb;
    logic          mem_r_ready, mem_r_valid, mem_w_valid, mem_w_ready;
    logic [AW-1:0] mem_r_addr, mem_w_addr;
    logic [DW-1:0] mem_r_data, mem_w_data;
    logic [SW-1:0] mem_w_strb;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_LSU_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_r_ready(ifu_r_ready), .ifu_r_addr(ifu_r_addr), .ifu_gnt(ifu_gnt),
        .ifu_r_valid(ifu_r_valid), .ifu_r_data(ifu_r_data),
        .lsu_r_ready(lsu_r_ready), .lsu_w_valid(lsu_w_valid), .lsu_addr(lsu_addr),
        .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_gnt(lsu_gnt),
        .lsu_r_valid(lsu_r_valid), .lsu_r_data(lsu_r_data), .lsu_w_ready(lsu_w_ready),
        .lsu_idle(lsu_idle),
        .mem_r_ready(mem_r_ready), .mem_r_addr(mem_r_addr), .mem_r_valid(mem_r_valid),
        .mem_r_data(mem_r_data), .mem_w_valid(mem_w_valid), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .mem_w_strb(mem_w_strb), .mem_w_ready(mem_w_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: filled by the stimulus, drained by the monitor.
    logic [DW-1:0] ifu_q[$];
    logic [DW-1:0] lsu_rd_q[$];
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [SW-1:0] wq_strb[$];
    byte           exp_order[$];

    int errors = 0;
    int checks = 0;
    bit final_req = 0;
    bit final_done = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_A5A5, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: which requester holds the bus, and how long the IFU has been passed over.
    typedef enum int {K_NONE, K_IFU, K_LRD, K_LWR} kind_t;

    initial begin : monitor
        kind_t         inflight;
        logic [AW-1:0] infl_addr;
        int            run;
        bit            want_l, want_i, done;
        inflight = K_NONE;
        infl_addr = '0;
        run = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                chk("rst_mem_r_ready", 64'(mem_r_ready), 64'd0);
                chk("rst_mem_w_valid", 64'(mem_w_valid), 64'd0);
                chk("rst_lsu_idle", 64'(lsu_idle), 64'd1);
                chk("rst_grants", 64'({ifu_gnt, lsu_gnt}), 64'd0);
                chk("rst_responses", 64'({ifu_r_valid, lsu_r_valid, lsu_w_ready}), 64'd0);
                chk("rst_mem_addr", 64'(mem_r_addr | mem_w_addr), 64'd0);
                inflight = K_NONE;
                run = 0;
                ifu_q.delete(); lsu_rd_q.delete();
                wq_addr.delete(); wq_data.delete(); wq_strb.delete();
                continue;
            end
            if (inflight == K_NONE) begin
                want_l = (lsu_w_valid || lsu_r_ready) && !(ifu_r_ready && run == MAXS);
                want_i = ifu_r_ready && !want_l;
                chk("lsu_gnt", 64'(lsu_gnt), 64'(want_l));
                chk("ifu_gnt", 64'(ifu_gnt), 64'(want_i));
                chk("lsu_idle_idle", 64'(lsu_idle), 64'(!want_l));
                chk("mem_req_idle", 64'({mem_r_ready, mem_w_valid}), 64'd0);
                chk("resp_in_idle", 64'({ifu_r_valid, lsu_r_valid, lsu_w_ready}), 64'd0);
                if ((want_l || want_i) && exp_order.size() > 0) begin
                    chk("grant_order", 64'(lsu_gnt ? "L" : (ifu_gnt ? "I" : "-")), 64'(exp_order.pop_front()));
                end
                if (want_l) begin
                    inflight  = lsu_w_valid ? K_LWR : K_LRD;
                    infl_addr = lsu_addr;
                    run = ifu_r_ready ? ((run < MAXS) ? run + 1 : MAXS) : 0;
                end else if (want_i) begin
                    inflight  = K_IFU;
                    infl_addr = ifu_r_addr;
                    run = 0;
                end
            end else begin
                chk("gnt_while_busy", 64'({ifu_gnt, lsu_gnt}), 64'd0);
                chk("mem_r_ready", 64'(mem_r_ready), 64'(inflight != K_LWR));
                chk("mem_w_valid", 64'(mem_w_valid), 64'(inflight == K_LWR));
                chk("mem_addr", 64'((inflight == K_LWR) ? mem_w_addr : mem_r_addr), 64'(infl_addr));
                chk("lsu_idle_busy", 64'(lsu_idle), 64'(inflight == K_IFU));
                chk("ifu_r_valid", 64'(ifu_r_valid), 64'(inflight == K_IFU && mem_r_valid));
                chk("lsu_r_valid", 64'(lsu_r_valid), 64'(inflight == K_LRD && mem_r_valid));
                chk("lsu_w_ready", 64'(lsu_w_ready), 64'(inflight == K_LWR && mem_w_ready));
                if (ifu_r_valid) begin
                    chk("ifu_q_depth", 64'(ifu_q.size() > 0), 64'd1);
                    if (ifu_q.size() > 0) chk("ifu_r_data", ifu_r_data, ifu_q.pop_front());
                end
                if (lsu_r_valid) begin
                    chk("lsu_rd_q_depth", 64'(lsu_rd_q.size() > 0), 64'd1);
                    if (lsu_rd_q.size() > 0) chk("lsu_r_data", lsu_r_data, lsu_rd_q.pop_front());
                end
                if (lsu_w_ready) begin
                    chk("wq_depth", 64'(wq_addr.size() > 0), 64'd1);
                    if (wq_addr.size() > 0) begin
                        chk("mem_w_addr", 64'(mem_w_addr), 64'(wq_addr.pop_front()));
                        chk("mem_w_data", mem_w_data, wq_data.pop_front());
                        chk("mem_w_strb", 64'(mem_w_strb), 64'(wq_strb.pop_front()));
                    end
                end
                done = (inflight == K_LWR) ? mem_w_ready : mem_r_valid;
                if (done) inflight = K_NONE;
            end
            if (!ifu_r_valid) chk("ifu_r_data_zero", ifu_r_data, 64'd0);
            if (!lsu_r_valid) chk("lsu_r_data_zero", lsu_r_data, 64'd0);
            if (final_req && !final_done) begin
                chk("ifu_q_left", 64'(ifu_q.size()), 64'd0);
                chk("lsu_rd_q_left", 64'(lsu_rd_q.size()), 64'd0);
                chk("wq_left", 64'(wq_addr.size()), 64'd0);
                chk("order_left", 64'(exp_order.size()), 64'd0);
                final_done = 1;
            end
        end
    end

    bit mem_auto = 0, spur = 0, req_auto = 0, allow_new = 0;
    bit ifu_pend = 0, lsu_pend = 0, gi, gl;
    int resp_pct = 100;

    task automatic mem_step();
        mem_r_valid = 0; mem_w_ready = 0; mem_r_data = '0;
        if (mem_r_ready) begin
            if ($urandom_range(99) < resp_pct) begin
                mem_r_valid = 1; mem_r_data = pat(mem_r_addr);
            end
            if (spur && $urandom_range(5) == 0) mem_w_ready = 1;
        end else if (mem_w_valid) begin
            if ($urandom_range(99) < resp_pct) mem_w_ready = 1;
            if (spur && $urandom_range(5) == 0) begin
                mem_r_valid = 1; mem_r_data = {$urandom, $urandom};
            end
        end else if (spur) begin
            mem_w_ready = ($urandom_range(7) == 0);
            if ($urandom_range(7) == 0) begin
                mem_r_valid = 1; mem_r_data = {$urandom, $urandom};
            end
        end
    endtask

    task automatic req_step();
        if (ifu_pend && gi) begin ifu_pend = 0; ifu_r_ready = 0; end
        if (lsu_pend && gl) begin lsu_pend = 0; lsu_r_ready = 0; lsu_w_valid = 0; end
        if (!ifu_pend && allow_new && $urandom_range(1) == 1) begin
            ifu_pend = 1; ifu_r_ready = 1;
            ifu_r_addr = $urandom & ~32'h7;
            ifu_q.push_back(pat(ifu_r_addr));
        end
        if (!lsu_pend && allow_new && $urandom_range(1) == 1) begin
            lsu_pend = 1;
            lsu_addr = $urandom & ~32'h7;
            if ($urandom_range(1) == 1) begin
                lsu_w_valid = 1;
                lsu_w_data = {$urandom, $urandom};
                lsu_w_strb = SW'($urandom);
                wq_addr.push_back(lsu_addr); wq_data.push_back(lsu_w_data); wq_strb.push_back(lsu_w_strb);
            end else begin
                lsu_r_ready = 1;
                lsu_rd_q.push_back(pat(lsu_addr));
            end
        end
    endtask

    // One bus cycle: grants observed mid-cycle, new stimulus applied just after the next edge.
    task automatic cyc();
        @(negedge clk);
        gi = ifu_gnt; gl = lsu_gnt;
        @(posedge clk);
        #1;
        if (mem_auto) mem_step();
        if (req_auto) req_step();
    endtask

    initial begin : stimulus
        int lsu_left;
        rst = 1;
        ifu_r_ready = 0; ifu_r_addr = '0;
        lsu_r_ready = 0; lsu_w_valid = 0; lsu_addr = '0; lsu_w_data = '0; lsu_w_strb = '0;
        mem_r_valid = 0; mem_r_data = '0; mem_w_ready = 0;
        repeat (3) cyc();
        rst = 0;

        ifu_r_ready = 1; ifu_r_addr = 32'h8000_0000;
        ifu_q.push_back(64'h1122_3344_5566_7788);
        cyc(); ifu_r_ready = 0;
        cyc(); mem_r_valid = 1; mem_r_data = 64'h1122_3344_5566_7788;
        cyc(); mem_r_valid = 0; mem_r_data = '0;
        cyc();

        lsu_w_valid = 1; lsu_addr = 32'h8000_0100; lsu_w_data = 64'hDEAD_BEEF; lsu_w_strb = 8'h0F;
        wq_addr.push_back(32'h8000_0100); wq_data.push_back(64'hDEAD_BEEF); wq_strb.push_back(8'h0F);
        cyc(); lsu_w_valid = 0;
        cyc();
        cyc(); mem_w_ready = 1;
        cyc(); mem_w_ready = 0;
        cyc();

        exp_order = '{"L", "L", "L", "L", "I", "L", "L"};
        ifu_r_ready = 1; ifu_r_addr = 32'h8000_2000; ifu_q.push_back(pat(32'h8000_2000));
        lsu_left = 6; lsu_r_ready = 1; lsu_addr = 32'h4000_0000; lsu_rd_q.push_back(pat(lsu_addr));
        mem_auto = 1; resp_pct = 100; spur = 0;
        for (int i = 0; i < 60 && (lsu_left > 0 || ifu_r_ready); i++) begin
            cyc();
            if (gi) ifu_r_ready = 0;
            if (gl) begin
                lsu_left--;
                if (lsu_left > 0) begin
                    lsu_addr = lsu_addr + 32'h8;
                    lsu_rd_q.push_back(pat(lsu_addr));
                end else begin
                    lsu_r_ready = 0;
                end
            end
        end
        cyc(); cyc();
        mem_auto = 0; mem_r_valid = 0; mem_r_data = '0;

        lsu_r_ready = 1; lsu_addr = 32'h8000_0300; lsu_rd_q.push_back(pat(lsu_addr));
        cyc(); lsu_r_ready = 0;
        #2 rst = 1;
        cyc(); rst = 0;
        mem_r_valid = 1; mem_r_data = 64'hBAD0_BAD0_BAD0_BAD0;
        cyc(); mem_r_valid = 0; mem_r_data = '0;

        mem_r_valid = 1; mem_r_data = 64'h5555_AAAA_5555_AAAA; mem_w_ready = 1;
        cyc(); mem_r_valid = 0; mem_w_ready = 0;
        ifu_r_ready = 1; ifu_r_addr = 32'h8000_0400; ifu_q.push_back(64'h0123_4567_89AB_CDEF);
        cyc(); ifu_r_ready = 0; mem_w_ready = 1;
        cyc(); mem_w_ready = 0; mem_r_valid = 1; mem_r_data = 64'h0123_4567_89AB_CDEF;
        cyc(); mem_r_valid = 0; mem_r_data = '0;

        lsu_w_valid = 1; lsu_r_ready = 1; lsu_addr = 32'h8000_0500;
        lsu_w_data = 64'hCAFE_F00D_0000_0001; lsu_w_strb = 8'hF0;
        wq_addr.push_back(lsu_addr); wq_data.push_back(lsu_w_data); wq_strb.push_back(lsu_w_strb);
        cyc(); lsu_w_valid = 0; lsu_r_ready = 0;
        cyc(); mem_w_ready = 1;
        cyc(); mem_w_ready = 0;
        cyc();

        mem_auto = 1; resp_pct = 40; spur = 1; req_auto = 1; allow_new = 1;
        repeat (1500) cyc();
        allow_new = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ifu_pend && !lsu_pend && ifu_q.size() == 0 && lsu_rd_q.size() == 0 && wq_addr.size() == 0) break;
            cyc();
        end
        req_auto = 0; spur = 0;
        cyc();

        final_req = 1;
        for (int i = 0; i < 10 && !final_done; i++) cyc();
        if (!final_done) begin
            $display("FAIL final_check: monitor did not complete its final comparisons");
            $fatal(1, "monitor stalled");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
